// File: rtl/array_multiplier.sv
// 16x16 unsigned carry-save array multiplier with a registered 32-bit product.
// The partial-product array and the final ripple stage are pure combinational logic.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module array_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_A,
  input  logic [15:0] in_B,
  output logic [31:0] prod_out
);
  localparam int unsigned W = 16;

  logic [W-1:0]   pp [W];
  logic [W-1:0]   s  [W];
  logic [W-1:0]   c  [1:W-1];
  logic [W-2:0]   rc;
  logic [2*W-1:0] prod_c;

  genvar i, j, k;

  // Partial products: row i is in_A gated by multiplier bit i.
  for (i = 0; i < W; i++) begin : g_pp
    assign pp[i] = in_A & {W{in_B[i]}};
  end

  assign s[0]      = pp[0];
  assign prod_c[0] = s[0][0];

  // Carry-save rows: row i adds pp[i] to the previous row's shifted sums and its carries.
  for (i = 1; i < W; i++) begin : g_row
    for (j = 0; j < W - 1; j++) begin : g_col
      if (i == 1) begin : g_ha
        half_adder u_ha (
          .a    (pp[i][j]),
          .b    (s[i-1][j+1]),
          .sum  (s[i][j]),
          .cout (c[i][j])
        );
      end else begin : g_fa
        full_adder u_fa (
          .a    (pp[i][j]),
          .b    (s[i-1][j+1]),
          .cin  (c[i-1][j]),
          .sum  (s[i][j]),
          .cout (c[i][j])
        );
      end
    end

    // Leftmost cell has no shifted sum input; row 1 has no incoming carry either.
    if (i == 1) begin : g_msb_first
      assign s[i][W-1] = pp[i][W-1];
      assign c[i][W-1] = 1'b0;
    end else begin : g_msb
      half_adder u_ha_msb (
        .a    (pp[i][W-1]),
        .b    (c[i-1][W-1]),
        .sum  (s[i][W-1]),
        .cout (c[i][W-1])
      );
    end

    assign prod_c[i] = s[i][0];
  end

  // Final carry-propagate stage resolves the last row's sums and carries into bits 31..16.
  half_adder u_cpa0 (
    .a    (s[W-1][1]),
    .b    (c[W-1][0]),
    .sum  (prod_c[W]),
    .cout (rc[0])
  );

  for (k = 1; k < W - 1; k++) begin : g_cpa
    full_adder u_cpa (
      .a    (s[W-1][k+1]),
      .b    (c[W-1][k]),
      .cin  (rc[k-1]),
      .sum  (prod_c[W+k]),
      .cout (rc[k])
    );
  end

  // The product fits in 32 bits, so the carry out of the top bit is always zero.
  assign prod_c[2*W-1] = c[W-1][W-1] ^ rc[W-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod_out <= '0;
    else     prod_out <= prod_c;
  end

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier: reset, corners, random streaming and mid-stream reset.

module tb_array_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_A;
  logic [15:0] in_B;
  logic [31:0] prod_out;

  int tests = 0;
  int fails = 0;

  array_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .in_A     (in_A),
    .in_B     (in_B),
    .prod_out (prod_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] exp);
    tests++;
    assert (prod_out === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, prod_out, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ca [4];
  logic [15:0] cb [4];
  logic [31:0] cp [4];
  logic [31:0] prev;
  logic [31:0] exp_q [$];

  initial begin
    ca[0] = 16'h0000; cb[0] = 16'hABCD; cp[0] = 32'h00000000;
    ca[1] = 16'h0001; cb[1] = 16'hBEEF; cp[1] = 32'h0000BEEF;
    ca[2] = 16'hFFFF; cb[2] = 16'hFFFF; cp[2] = 32'hFFFE0001;
    ca[3] = 16'h8000; cb[3] = 16'h0002; cp[3] = 32'h00010000;

    // Reset held with clock running and non-zero inputs.
    rst  = 1'b1;
    in_A = 16'h1234;
    in_B = 16'h5678;
    #2;
    chk("reset_async", 32'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("reset_hold", 32'h0);
    end
    rst = 1'b0;
    #2;
    chk("reset_release_no_edge", 32'h0);
    tick();
    chk("reset_first_edge", 32'h06260060);

    // Corner operand pairs, one cycle each.
    for (int n = 0; n < 4; n++) begin
      in_A = ca[n];
      in_B = cb[n];
      tick();
      chk($sformatf("corner%0d", n), cp[n]);
    end

    // Back-to-back random pairs: result lags inputs by exactly one edge.
    prev = cp[3];
    for (int n = 0; n < 20; n++) begin
      in_A = 16'($urandom);
      in_B = 16'($urandom);
      if (n == 5) in_A = 16'hFFFF;
      if (n == 9) in_B = 16'h0000;
      exp_q.push_back(model(in_A, in_B));
      #2;
      chk($sformatf("hold_before_edge%0d", n), prev);
      tick();
      prev = exp_q.pop_front();
      chk($sformatf("rand%0d", n), prev);
      if (prod_out === prev)
        $display("[TB] vector %0d A=%h B=%h prod=%h ok", n, in_A, in_B, prod_out);
    end

    // Asynchronous reset pulse between edges while streaming.
    in_A = 16'h3C5A;
    in_B = 16'h9E17;
    tick();
    chk("stream_before_pulse", model(16'h3C5A, 16'h9E17));
    in_A = 16'h7001;
    in_B = 16'h00F3;
    #2 rst = 1'b1;
    #1;
    chk("pulse_async_clear", 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("pulse_released_no_edge", 32'h0);
    tick();
    chk("pulse_first_edge", model(16'h7001, 16'h00F3));
    in_A = 16'hFFFF;
    in_B = 16'h0001;
    tick();
    chk("after_pulse_stream", 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
